uart_tx_buffer: RTL and testbench

- Sits between the two UART transmit producers (DMA controller, memory controller hub) and the byte-wide UartTx.
- Replaces the OR-merge of the producers' start pulses with arbitrated valid/ready intake, a word FIFO, and a byte serializer.
- Each accepted entry is a 32-bit word plus a byte count. Bytes go to UartTx LSB first, one per UartTx frame, and never overlap a busy transmitter.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_buffer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and widths for the UART transmit/receive buffering blocks.
//   - WORD_W / BYTE_W / LEN_W : word, byte and byte-count field widths
//   - tx_entry_t              : one queued transmit entry {len, data}
//   - ser_state_t             : byte serializer state
package uart_pkg;

    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int LEN_W   = 2;
    localparam int ENTRY_W = LEN_W + WORD_W;

    // len holds (byte count - 1); bytes leave LSB first.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [WORD_W-1:0] data;
    } tx_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO of 2**DEPTH_LOG2 entries. The head entry is presented
//   straight from the storage registers, so o_rd_data is valid whenever
//   o_empty is low and a pop simply advances the read pointer.
// Ports:
//   i_clock, i_reset  : clock, asynchronous active-high reset
//   i_wr_en/i_wr_data : push (ignored while full)
//   i_rd_en/o_rd_data : pop (ignored while empty) / current head
//   o_full, o_empty   : status from the registered pointers
//   o_level           : occupancy, 0 .. 2**DEPTH_LOG2
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_wr;
    logic                w_rd;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // low bits with differing wrap bits mean full.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge i_clock) begin
        if (w_wr) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Front end for the byte-wide UartTx. Two producers (A = DMA, B = MCH)
//   offer {len, word} entries over valid/ready; A wins a same-cycle
//   collision. Entries queue in a sync_fifo and a serializer feeds the
//   word to UartTx one byte per frame, LSB first, never while it is busy.
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   a_valid/a_data/a_len     : producer A offer (len = bytes - 1)
//   a_ready                  : A accepted this cycle when valid && ready
//   b_valid/b_data/b_len     : producer B offer
//   b_ready                  : B accept (low whenever A is offering)
//   tx_busy                  : UartTx busy
//   tx_start, sdata          : registered one-cycle start pulse + byte
//   level                    : FIFO occupancy
//   idle                     : nothing queued, serializer idle, UartTx idle
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [WORD_W-1:0]     a_data,
    input  logic [LEN_W-1:0]      a_len,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [WORD_W-1:0]     b_data,
    input  logic [LEN_W-1:0]      b_len,
    output logic                  b_ready,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [BYTE_W-1:0]     sdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  idle
);

    localparam int GW    = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam int REM_W = LEN_W + 1;

    // ---------------- intake arbitration ----------------
    logic         w_full;
    logic         w_empty;
    logic         w_a_ready;
    logic         w_b_ready;
    logic         w_wr_en;
    tx_entry_t    w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_raw;
    tx_entry_t    w_head;
    logic         w_pop;

    // Ready depends only on the registered full flag and a_valid, so a pop
    // from a full FIFO opens a slot one cycle later, and B never sees its
    // own valid reflected back into its ready.
    assign w_a_ready = !w_full;
    assign w_b_ready = !w_full && !a_valid;
    assign w_wr_en   = (a_valid && w_a_ready) || (b_valid && w_b_ready);

    always_comb begin
        w_wr_entry = '{len: b_len, data: b_data};
        if (a_valid) w_wr_entry = '{len: a_len, data: a_data};
    end

    // ---------------- word FIFO ----------------
    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_raw),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    assign w_head = w_rd_raw;

    // ---------------- byte serializer ----------------
    ser_state_t          r_state;
    logic [WORD_W-1:0]   r_sh;
    logic [REM_W-1:0]    r_rem;
    logic [GW-1:0]       r_guard;
    logic                r_tx_start;
    logic [BYTE_W-1:0]   r_sdata;

    // The head is taken as soon as the serializer is idle, regardless of
    // tx_busy; the wait for the transmitter happens in SEND.
    assign w_pop = (r_state == IDLE) && !w_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_rem      <= '0;
            r_guard    <= '0;
            r_tx_start <= 1'b0;
            r_sdata    <= '0;
        end else begin
            r_tx_start <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_sh    <= w_head.data;
                        r_rem   <= {1'b0, w_head.len} + REM_W'(1);
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_sdata    <= r_sh[BYTE_W-1:0];
                        r_sh       <= r_sh >> BYTE_W;
                        r_rem      <= r_rem - REM_W'(1);
                        r_guard    <= GW'(GUARD_CYCLES);
                        r_state    <= GUARD;
                    end
                end
                GUARD: begin
                    // tx_busy lags tx_start inside UartTx; during this
                    // window a low busy is stale and must not be trusted.
                    if (r_guard <= GW'(1)) begin
                        r_guard <= '0;
                        r_state <= (r_rem != '0) ? SEND : IDLE;
                    end else begin
                        r_guard <= r_guard - GW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a_ready  = w_a_ready;
    assign b_ready  = w_b_ready;
    assign tx_start = r_tx_start;
    assign sdata    = r_sdata;
    assign idle     = w_empty && (r_state == IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

    logic        clock, reset;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_len, b_len;
    logic        tx_busy, tx_start, idle;
    logic [7:0]  sdata;
    logic [4:0]  level;

    int n_cmp = 0;
    int n_err = 0;
    int viol = 0;       // tx_start seen while tx_busy high
    int lvl_over = 0;   // level seen above 16
    int busy_cnt = 0;
    int busy_len;
    logic stuck;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_tx_buffer #(.DEPTH_LOG2(4), .GUARD_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_len(a_len), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_len(b_len), .b_ready(b_ready),
        .tx_busy(tx_busy), .tx_start(tx_start), .sdata(sdata),
        .level(level), .idle(idle)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // UartTx model: busy rises the cycle after tx_start, lasts busy_len cycles.
    always @(posedge clock or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = stuck || (busy_cnt != 0);

    always @(negedge clock) begin
        if (!reset) begin
            if (tx_start) begin
                got_q.push_back(sdata);
                if (tx_busy) viol <= viol + 1;
            end
            if (level > 5'd16) lvl_over <= lvl_over + 1;
        end
    end

    task automatic add_exp(input logic [31:0] d, input logic [1:0] l);
        for (int k = 0; k <= int'(l); k++) exp_q.push_back(d[8*k +: 8]);
    endtask

    // Offer one word on side A or B and hold it until accepted.
    task automatic push(input bit side_b, input logic [31:0] d, input logic [1:0] l);
        int t = 0;
        if (side_b) begin b_valid = 1; b_data = d; b_len = l; end
        else begin a_valid = 1; a_data = d; a_len = l; end
        #1;
        while (!(side_b ? b_ready : a_ready) && t < 500) begin
            @(negedge clock); #1; t++;
        end
        @(negedge clock);
        a_valid = 0; b_valid = 0;
        if (t >= 500) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: word %h not accepted, required accept within 500 cycles", d);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clock);
            if (idle) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst.tx_start: got %b want 0", tx_start); end
        n_cmp++; if (sdata !== 8'h00) begin n_err++; $display("FAIL rst.sdata: got %h want 00", sdata); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rst.level: got %0d want 0", level); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst.idle: got %b want 1", idle); end
        reset = 0;
        @(negedge clock);
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rst.a_ready: got %b want 1", a_ready); end
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL rst.b_ready: got %b want 1", b_ready); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst.idle_after: got %b want 1", idle); end
    endtask

    task automatic test_single;
        bit ok;
        busy_len = 20;
        push(0, 32'h44332211, 2'd3);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL single.count: got %0d bytes idle=%0b want %0d bytes idle=1", got_q.size(), ok, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL single.byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL single.busy_overlap: got %0d want 0", viol); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_latency;
        bit ok;
        busy_len = 3;
        a_valid = 1; a_data = 32'h0000005A; a_len = 2'd0;
        @(negedge clock); a_valid = 0;
        n_cmp++; if (tx_start !== 1'b0 || level !== 5'd1) begin n_err++; $display("FAIL lat.cyc1: got start=%b level=%0d want start=0 level=1", tx_start, level); end
        @(negedge clock);
        n_cmp++; if (tx_start !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL lat.cyc2: got start=%b level=%0d want start=0 level=0", tx_start, level); end
        @(negedge clock);
        n_cmp++; if (tx_start !== 1'b1 || sdata !== 8'h5A) begin n_err++; $display("FAIL lat.cyc3: got start=%b sdata=%h want start=1 sdata=5a", tx_start, sdata); end
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != 1) begin n_err++; $display("FAIL lat.count: got %0d bytes idle=%0b want 1 byte idle=1", got_q.size(), ok); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_collision;
        bit ok;
        busy_len = 5;
        a_valid = 1; a_data = 32'h000000AA; a_len = 2'd0;
        b_valid = 1; b_data = 32'h000000BB; b_len = 2'd0;
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL coll.ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
        @(negedge clock); a_valid = 0; #1;
        n_cmp++; if (b_ready !== 1'b1 || level !== 5'd1) begin n_err++; $display("FAIL coll.b_turn: got b_ready=%b level=%0d want 1 1", b_ready, level); end
        @(negedge clock); b_valid = 0;
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL coll.level: got %0d want 1", level); end
        exp_q = '{8'hAA, 8'hBB};
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL coll.count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL coll.byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    // The first word leaves the FIFO into the serializer even while busy,
    // so 17 pushes fill the 16 slots and an 18th must be held off.
    task automatic test_full;
        bit ok;
        logic [31:0] d;
        busy_len = 4;
        stuck = 1;
        for (int i = 0; i < 17; i++) begin
            d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            push(bit'(i % 2), d, 2'(i % 4));
            add_exp(d, 2'(i % 4));
        end
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL full.level: got %0d want 16", level); end
        a_valid = 1; a_data = 32'hCAFEF00D; a_len = 2'd3;
        b_valid = 1; b_data = 32'h0BADBEEF; b_len = 2'd0;
        repeat (4) @(negedge clock);
        n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL full.ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
        n_cmp++; if (level !== 5'd16 || got_q.size() != 0) begin n_err++; $display("FAIL full.hold: got level=%0d bytes=%0d want 16 0", level, got_q.size()); end
        a_valid = 0; b_valid = 0;
        stuck = 0;
        push(0, 32'hCAFEF00D, 2'd3);
        add_exp(32'hCAFEF00D, 2'd3);
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL full.count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL full.byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_guard;
        bit ok;
        busy_len = 1;
        push(1, 32'hDDCCBBAA, 2'd3);
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL guard.count: got %0d pulses want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL guard.byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL guard.busy_overlap: got %0d want 0", viol); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap;
        bit ok;
        logic [31:0] d;
        busy_len = 2;
        for (int i = 0; i < 40; i++) begin
            d = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
            push(bit'(i % 3 == 0), d, 2'((i * 7) % 4));
            add_exp(d, 2'((i * 7) % 4));
        end
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL wrap.count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL wrap.byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (lvl_over != 0) begin n_err++; $display("FAIL wrap.level_max: got %0d over-16 samples want 0", lvl_over); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL wrap.busy_overlap: got %0d want 0", viol); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        bit ok;
        int t;
        busy_len = 20;
        push(0, 32'h87654321, 2'd3);
        push(0, 32'h00000001, 2'd0);
        push(1, 32'h00000002, 2'd0);
        push(0, 32'h00000003, 2'd0);
        n_cmp++; if (level !== 5'd3) begin n_err++; $display("FAIL rmid.level_pre: got %0d want 3", level); end
        t = 0;
        while (got_q.size() < 2 && t < 500) begin @(negedge clock); t++; end
        n_cmp++; if (got_q.size() != 2 || got_q[1] !== 8'h43) begin n_err++; $display("FAIL rmid.second_byte: got %0d bytes want 2 with byte1=43", got_q.size()); end
        @(negedge clock);
        #2 reset = 1;
        #1;
        n_cmp++; if (tx_start !== 1'b0 || sdata !== 8'h00) begin n_err++; $display("FAIL rmid.out: got start=%b sdata=%h want 0 00", tx_start, sdata); end
        n_cmp++; if (level !== 5'd0 || idle !== 1'b1) begin n_err++; $display("FAIL rmid.state: got level=%0d idle=%b want 0 1", level, idle); end
        @(negedge clock);
        reset = 0;
        got_q.delete(); exp_q.delete();
        @(negedge clock);
        push(1, 32'h0D0C0B0A, 2'd3);
        exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rmid.count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rmid.byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        reset = 1; stuck = 0; busy_len = 20;
        a_valid = 0; a_data = '0; a_len = '0;
        b_valid = 0; b_data = '0; b_len = '0;
        test_reset();
        test_single();
        test_latency();
        test_collision();
        test_full();
        test_guard();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
